// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between execute and load unit, with a registered register-file
// write port and a load scoreboard that drives the issue-stage stall.
module regfile_wb_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exec_valid_i,
  input  logic [4:0]  exec_rd_i,
  input  logic [31:0] exec_value_i,
  output logic        exec_ready_o,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_rd_i,
  input  logic [31:0] mem_value_i,
  output logic        mem_ready_o,
  input  logic        load_issue_i,
  input  logic [4:0]  load_issue_rd_i,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  output logic [4:0]  rd0_o,
  output logic [31:0] rd0_value_o,
  output logic [31:0] busy_o,
  output logic        stall_o
);

  localparam logic LAST_MEM  = 1'b0;
  localparam logic LAST_EXEC = 1'b1;

  logic        r_lastGrant;
  logic [4:0]  r_rd0;
  logic [31:0] r_rd0Value;
  logic [31:0] r_busy;

  logic        w_execGrant;
  logic        w_memGrant;
  logic [31:0] w_busyNext;
  logic        w_raBusy;
  logic        w_rbBusy;
  logic        w_rd0Hazard;

  // On a conflict the side that did not win last time gets the port.
  assign w_execGrant = exec_valid_i & (~mem_valid_i | (r_lastGrant == LAST_MEM));
  assign w_memGrant  = mem_valid_i  & (~exec_valid_i | (r_lastGrant == LAST_EXEC));

  assign exec_ready_o = w_execGrant;
  assign mem_ready_o  = w_memGrant;

  // Clear is applied before set so a new load to the same register keeps it busy.
  always_comb begin
    w_busyNext = r_busy;
    if (w_memGrant) begin
      w_busyNext[mem_rd_i] = 1'b0;
    end
    if (load_issue_i && (load_issue_rd_i != 5'd0)) begin
      w_busyNext[load_issue_rd_i] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lastGrant <= LAST_MEM;
      r_rd0       <= 5'd0;
      r_rd0Value  <= 32'd0;
      r_busy      <= 32'd0;
    end else begin
      r_busy <= w_busyNext;
      if (w_execGrant) begin
        r_lastGrant <= LAST_EXEC;
        r_rd0       <= exec_rd_i;
        r_rd0Value  <= exec_value_i;
      end else if (w_memGrant) begin
        r_lastGrant <= LAST_MEM;
        r_rd0       <= mem_rd_i;
        r_rd0Value  <= mem_value_i;
      end else begin
        r_rd0      <= 5'd0;
        r_rd0Value <= 32'd0;
      end
    end
  end

  // The rd0 term covers the cycle before the registered write lands in the file.
  assign w_raBusy    = (ra_i != 5'd0) & r_busy[ra_i];
  assign w_rbBusy    = (rb_i != 5'd0) & r_busy[rb_i];
  assign w_rd0Hazard = (r_rd0 != 5'd0) & ((r_rd0 == ra_i) | (r_rd0 == rb_i));

  assign stall_o     = w_raBusy | w_rbBusy | w_rd0Hazard;
  assign rd0_o       = r_rd0;
  assign rd0_value_o = r_rd0Value;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic compared every cycle against a behavioural model of the arbiter.
module tb_regfile_wb_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        exec_valid_i;
  logic [4:0]  exec_rd_i;
  logic [31:0] exec_value_i;
  logic        exec_ready_o;
  logic        mem_valid_i;
  logic [4:0]  mem_rd_i;
  logic [31:0] mem_value_i;
  logic        mem_ready_o;
  logic        load_issue_i;
  logic [4:0]  load_issue_rd_i;
  logic [4:0]  ra_i;
  logic [4:0]  rb_i;
  logic [4:0]  rd0_o;
  logic [31:0] rd0_value_o;
  logic [31:0] busy_o;
  logic        stall_o;

  int totalCount = 0;
  int badCount   = 0;

  // Behavioural model state: last winner (0 = mem, 1 = exec), write port, scoreboard.
  int          mLastWinner;
  logic [4:0]  mRd0;
  logic [31:0] mRd0Value;
  logic [31:0] mBusy;

  logic seenExecReady;
  logic seenMemReady;
  logic seenStall;

  regfile_wb_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .exec_valid_i(exec_valid_i), .exec_rd_i(exec_rd_i), .exec_value_i(exec_value_i),
    .exec_ready_o(exec_ready_o),
    .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_value_i(mem_value_i),
    .mem_ready_o(mem_ready_o),
    .load_issue_i(load_issue_i), .load_issue_rd_i(load_issue_rd_i),
    .ra_i(ra_i), .rb_i(rb_i),
    .rd0_o(rd0_o), .rd0_value_o(rd0_value_o), .busy_o(busy_o), .stall_o(stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, checks every output against the model at the
  // falling edge, then advances the model across the rising edge.
  task automatic applyStimulus(
    input logic rst,
    input logic ev, input logic [4:0] erd, input logic [31:0] evl,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mvl,
    input logic li, input logic [4:0] lrd,
    input logic [4:0] ra, input logic [4:0] rb);
    int winner;
    logic expStall;
    logic [4:0]  nRd0;
    logic [31:0] nVal;
    logic [31:0] nBusy;
    int nLast;

    rst_i = rst;
    exec_valid_i = ev; exec_rd_i = erd; exec_value_i = evl;
    mem_valid_i = mv; mem_rd_i = mrd; mem_value_i = mvl;
    load_issue_i = li; load_issue_rd_i = lrd;
    ra_i = ra; rb_i = rb;

    @(negedge clk_i);
    winner = 0;
    if (ev && mv) winner = (mLastWinner == 1) ? 2 : 1;
    else if (ev) winner = 1;
    else if (mv) winner = 2;

    expStall = 1'b0;
    if (ra != 0 && mBusy[ra]) expStall = 1'b1;
    if (rb != 0 && mBusy[rb]) expStall = 1'b1;
    if (mRd0 != 0 && (mRd0 == ra || mRd0 == rb)) expStall = 1'b1;

    seenExecReady = exec_ready_o;
    seenMemReady  = mem_ready_o;
    seenStall     = stall_o;

    checkOutput("execRdy", {31'd0, exec_ready_o}, {31'd0, winner == 1});
    checkOutput("memRdy",  {31'd0, mem_ready_o},  {31'd0, winner == 2});
    checkOutput("stall",   {31'd0, stall_o},      {31'd0, expStall});
    checkOutput("rd0",     {27'd0, rd0_o},        {27'd0, mRd0});
    checkOutput("rd0Val",  rd0_value_o,           mRd0Value);
    checkOutput("busy",    busy_o,                mBusy);

    if (rst) begin
      nRd0 = 5'd0; nVal = 32'd0; nBusy = 32'd0; nLast = 0;
    end else begin
      nLast = mLastWinner;
      nRd0 = 5'd0; nVal = 32'd0;
      if (winner == 1) begin nRd0 = erd; nVal = evl; nLast = 1; end
      if (winner == 2) begin nRd0 = mrd; nVal = mvl; nLast = 0; end
      nBusy = mBusy;
      if (winner == 2) nBusy[mrd] = 1'b0;
      if (li && lrd != 0) nBusy[lrd] = 1'b1;
      nBusy[0] = 1'b0;
    end

    @(posedge clk_i);
    mRd0 = nRd0; mRd0Value = nVal; mBusy = nBusy; mLastWinner = nLast;
    #1;
  endtask

  task automatic idleCycle(input logic [4:0] ra, input logic [4:0] rb);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra, rb);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  logic        pendE, pendM;
  logic [4:0]  pErd, pMrd;
  logic [31:0] pEvl, pMvl;

  initial begin
    rst_i = 1'b1;
    exec_valid_i = 1'b0; exec_rd_i = 5'd0; exec_value_i = 32'd0;
    mem_valid_i = 1'b0; mem_rd_i = 5'd0; mem_value_i = 32'd0;
    load_issue_i = 1'b0; load_issue_rd_i = 5'd0;
    ra_i = 5'd0; rb_i = 5'd0;
    repeat (2) @(posedge clk_i);
    #1;
    mLastWinner = 0; mRd0 = 5'd0; mRd0Value = 32'd0; mBusy = 32'd0;

    $display("[TB] reset state");
    resetCycle();

    $display("[TB] single exec writeback");
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("r35Rdy", {31'd0, seenExecReady}, 32'd1);
    checkOutput("r35Rd0", {27'd0, rd0_o}, 32'd5);
    checkOutput("r35Val", rd0_value_o, 32'hDEADBEEF);
    idleCycle(5'd0, 5'd0);
    checkOutput("r35Clr", {27'd0, rd0_o}, 32'd0);

    $display("[TB] round-robin conflict");
    resetCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 5'd1, 32'h1111, 1'b1, 5'd2, 32'h2222, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("r36Exec", {31'd0, seenExecReady}, {31'd0, (k % 2) == 0});
      checkOutput("r36Excl", {31'd0, seenExecReady & seenMemReady}, 32'd0);
    end

    $display("[TB] load scoreboard stall");
    idleCycle(5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
    idleCycle(5'd7, 5'd0);
    checkOutput("r37Stall", {31'd0, seenStall}, 32'd1);
    checkOutput("r37Busy", {31'd0, busy_o[7]}, 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0);
    idleCycle(5'd7, 5'd0);
    checkOutput("r37Win", {31'd0, seenStall}, 32'd1);
    checkOutput("r37Free", {31'd0, busy_o[7]}, 32'd0);
    idleCycle(5'd7, 5'd0);
    checkOutput("r37Done", {31'd0, seenStall}, 32'd0);

    $display("[TB] set and clear collide");
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd0, 5'd0);
    checkOutput("r38Busy9", {31'd0, busy_o[9]}, 32'd1);
    resetCycle();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("r38Zero", busy_o, 32'd0);

    $display("[TB] exec to x0");
    resetCycle();
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("r39Rdy", {31'd0, seenExecReady}, 32'd1);
    checkOutput("r39Rd0", {27'd0, rd0_o}, 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("r39Mem", {31'd0, seenMemReady}, 32'd1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd8, 32'hCAFE, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("r40Busy", busy_o, 32'd0);
    checkOutput("r40Rd0", {27'd0, rd0_o}, 32'd0);
    checkOutput("r40Val", rd0_value_o, 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("r40Exec", {31'd0, seenExecReady}, 32'd1);

    $display("[TB] random traffic");
    pendE = 1'b0; pendM = 1'b0;
    pErd = 5'd0; pMrd = 5'd0; pEvl = 32'd0; pMvl = 32'd0;
    for (int n = 0; n < 400; n++) begin
      logic rst, li;
      logic [4:0] lrd, ra, rb;
      if (!pendE && ($urandom % 3 == 0)) begin
        pendE = 1'b1; pErd = 5'($urandom % 16); pEvl = $urandom;
      end
      if (!pendM && ($urandom % 3 == 0)) begin
        pendM = 1'b1; pMrd = 5'($urandom % 16); pMvl = $urandom;
      end
      rst = ($urandom % 60 == 0);
      li  = ($urandom % 4 == 0);
      lrd = 5'($urandom % 16);
      ra  = 5'($urandom % 16);
      rb  = 5'($urandom % 16);
      applyStimulus(rst, pendE, pErd, pEvl, pendM, pMrd, pMvl, li, lrd, ra, rb);
      if (rst) begin
        pendE = 1'b0; pendM = 1'b0;
      end else begin
        if (seenExecReady) pendE = 1'b0;
        if (seenMemReady)  pendM = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
